// File: rtl/uart_tx_packet_arbiter_if.sv
// Requester byte streams and the UART transmitter byte port shared by one arbiter.
interface uart_tx_packet_arbiter_if #(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned DATA_BIT = 8
);
    logic [NUM_REQ*DATA_BIT-1:0] req_data;
    logic [NUM_REQ-1:0]          req_valid;
    logic [NUM_REQ-1:0]          req_last;
    logic [NUM_REQ-1:0]          req_ready;
    logic [DATA_BIT-1:0]         tx_data;
    logic                        tx_data_valid;
    logic                        tx_data_ready;

    // Arbiter side
    modport master (
        input  req_data, req_valid, req_last, tx_data_ready,
        output req_ready, tx_data, tx_data_valid
    );

    // Requesters plus transmitter side
    modport slave (
        output req_data, req_valid, req_last, tx_data_ready,
        input  req_ready, tx_data, tx_data_valid
    );
endinterface

// File: rtl/uart_tx_packet_arbiter.sv
// Round-robin packet arbiter sharing one UART transmitter among NUM_REQ byte streams,
// with an idle gap after each packet and a pause that blocks new grants.
module uart_tx_packet_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_BIT   = 8,
    parameter int unsigned MAX_PKT    = 16,
    parameter int unsigned GAP_CYCLES = 100
) (
    input  logic                       clk,
    input  logic                       n_reset,
    uart_tx_packet_arbiter_if.master   bus,
    input  logic                       pause,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy,
    output logic                       pkt_trunc
);
    localparam int unsigned ID_W  = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = 8;
    localparam int unsigned GAP_W = 16;
    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_PKT);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_GAP} state_e;

    state_e            state_q, state_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]   grant_q, grant_d;
    logic [CNT_W-1:0]  byte_cnt_q, byte_cnt_d;
    logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
    logic              trunc_q, trunc_d;

    logic              pick_found;
    logic [ID_W-1:0]   pick_idx;
    logic [ID_W-1:0]   scan_idx;
    logic              sel_valid;
    logic              sel_last;
    logic [DATA_BIT-1:0] sel_data;
    logic              xfer;
    logic [CNT_W-1:0]  cnt_inc;
    logic              pkt_end;
    logic [ID_W-1:0]   grant_next;

    // First valid requester scanning upward from rr_ptr, wrapping mod NUM_REQ
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = rr_ptr_q;
        scan_idx   = rr_ptr_q;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            scan_idx = ID_W'((32'(rr_ptr_q) + k) % NUM_REQ);
            if (!pick_found && bus.req_valid[scan_idx]) begin
                pick_found = 1'b1;
                pick_idx   = scan_idx;
            end
        end
    end

    assign sel_valid  = bus.req_valid[grant_q];
    assign sel_last   = bus.req_last[grant_q];
    assign sel_data   = bus.req_data[32'(grant_q)*DATA_BIT +: DATA_BIT];
    assign xfer       = (state_q == ST_SEND) && sel_valid && bus.tx_data_ready;
    assign cnt_inc    = byte_cnt_q + CNT_W'(1);
    assign pkt_end    = xfer && (sel_last || (cnt_inc == MAX_CNT));
    assign grant_next = ID_W'((32'(grant_q) + 32'd1) % NUM_REQ);

    // State register
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q    <= ST_IDLE;
            rr_ptr_q   <= '0;
            grant_q    <= '0;
            byte_cnt_q <= '0;
            gap_cnt_q  <= '0;
            trunc_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_q    <= grant_d;
            byte_cnt_q <= byte_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            trunc_q    <= trunc_d;
        end
    end

    // Next state and counters
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_d    = grant_q;
        byte_cnt_d = byte_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        trunc_d    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (!pause && pick_found) begin
                    grant_d = pick_idx;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (xfer) byte_cnt_d = cnt_inc;
                // A cut packet leaves the rest of the stream for a later grant
                if (pkt_end) begin
                    trunc_d    = !sel_last;
                    rr_ptr_d   = grant_next;
                    byte_cnt_d = '0;
                    state_d    = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    gap_cnt_d = '0;
                    state_d   = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Zero-latency pass-through of the granted requester while sending
    always_comb begin
        bus.tx_data       = '0;
        bus.tx_data_valid = 1'b0;
        bus.req_ready     = '0;
        if (state_q == ST_SEND) begin
            bus.tx_data            = sel_data;
            bus.tx_data_valid      = sel_valid;
            bus.req_ready[grant_q] = bus.tx_data_ready;
        end
    end

    assign grant_id  = grant_q;
    assign busy      = (state_q != ST_IDLE);
    assign pkt_trunc = trunc_q;

endmodule

// File: tb/tb_uart_tx_packet_arbiter.sv
// Scoreboard bench for uart_tx_packet_arbiter: requester queues feed the DUT,
// expected bytes with grant id, truncation and gap timing are checked on transfer.
module tb_uart_tx_packet_arbiter;
    localparam int unsigned NR   = 4;
    localparam int unsigned DW   = 8;
    localparam int unsigned MAXP = 16;
    localparam int unsigned GAP  = 12;
    localparam int          NEXT_GAP = GAP + 2;

    logic       clk = 1'b0;
    logic       n_reset = 1'b0;
    logic       pause = 1'b0;
    logic [1:0] grant_id;
    logic       busy;
    logic       pkt_trunc;

    uart_tx_packet_arbiter_if #(.NUM_REQ(NR), .DATA_BIT(DW)) bus ();

    uart_tx_packet_arbiter #(
        .NUM_REQ(NR), .DATA_BIT(DW), .MAX_PKT(MAXP), .GAP_CYCLES(GAP)
    ) dut (
        .clk(clk), .n_reset(n_reset), .bus(bus), .pause(pause),
        .grant_id(grant_id), .busy(busy), .pkt_trunc(pkt_trunc)
    );

    always #5 clk = ~clk;

    typedef struct {
        int id;
        int data;
        bit is_end;
        bit trunc;
        int gap;
    } exp_t;

    exp_t       exp_q[$];
    logic [8:0] rq[NR][$];
    int n_checks = 0, n_errors = 0;
    int cyc = 0, xfer_cnt = 0, last_end_cyc = 0;
    bit end_valid = 0, pend_trunc = 0, prev_busy = 0, ready_mode = 0;

    task automatic check_eq(input string tag, input int got, input int want);
        n_checks++;
        if (got != want) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    task automatic monitor();
        exp_t e;
        bit   xfer;
        xfer = bus.tx_data_valid && bus.tx_data_ready;
        check_eq("pkt_trunc", int'(pkt_trunc), int'(pend_trunc));
        pend_trunc = 1'b0;
        if (!bus.tx_data_ready) check_eq("req_ready_when_tx_stalled", int'(bus.req_ready), 0);
        if (!busy) check_eq("tx_valid_when_idle", int'(bus.tx_data_valid), 0);
        if (xfer) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_xfer", int'(bus.tx_data), -1);
            end else begin
                e = exp_q.pop_front();
                check_eq("grant_id", int'(grant_id), e.id);
                check_eq("tx_data", int'(bus.tx_data), e.data);
                check_eq("req_ready_onehot", int'(bus.req_ready), 1 << e.id);
                if (e.gap >= 0) check_eq("gap_between_grants", cyc - last_end_cyc, e.gap);
                if (e.is_end) begin
                    last_end_cyc = cyc;
                    end_valid    = 1'b1;
                end
                pend_trunc = e.trunc;
            end
            xfer_cnt++;
        end
        if (prev_busy && !busy && end_valid) begin
            check_eq("gap_len", cyc - last_end_cyc - 1, int'(GAP));
            end_valid = 1'b0;
        end
        prev_busy = busy;
    endtask

    task automatic drive();
        logic [8:0] h;
        for (int i = 0; i < int'(NR); i++) begin
            if (rq[i].size() > 0) begin
                h = rq[i][0];
                bus.req_valid[i]          = 1'b1;
                bus.req_last[i]           = h[8];
                bus.req_data[i*DW +: DW]  = h[7:0];
            end else begin
                bus.req_valid[i] = 1'b0;
                bus.req_last[i]  = 1'b0;
            end
        end
        bus.tx_data_ready = ready_mode ? (cyc % 4 == 0) : 1'b1;
    endtask

    // Requester/transmitter model: sample between edges, advance queues after the edge
    initial begin : drv_mon
        logic [NR-1:0] fire;
        bus.req_valid     = '0;
        bus.req_last      = '0;
        bus.req_data      = '0;
        bus.tx_data_ready = 1'b1;
        forever begin
            @(negedge clk);
            cyc++;
            fire = bus.req_valid & bus.req_ready;
            if (!n_reset) begin
                end_valid  = 1'b0;
                pend_trunc = 1'b0;
                prev_busy  = 1'b0;
            end else begin
                monitor();
            end
            @(posedge clk);
            #1;
            for (int i = 0; i < int'(NR); i++)
                if (fire[i] && rq[i].size() > 0) void'(rq[i].pop_front());
            drive();
        end
    end

    task automatic push_req(input int i, input int data, input bit last);
        rq[i].push_back({last, 8'(data)});
    endtask

    task automatic push_exp(input int id, input int data, input bit is_end, input bit trunc, input int gap);
        exp_t e;
        e = '{id, data, is_end, trunc, gap};
        exp_q.push_back(e);
    endtask

    // One complete packet from requester i with last on its final byte
    task automatic pkt(input int i, input int base, input int n, input int gap_first);
        for (int k = 0; k < n; k++) begin
            push_req(i, base + k, k == n - 1);
            push_exp(i, base + k, k == n - 1, 1'b0, (k == 0) ? gap_first : -1);
        end
    endtask

    function automatic int rq_pending();
        int s = 0;
        for (int i = 0; i < int'(NR); i++) s += rq[i].size();
        return s;
    endfunction

    task automatic wait_drain(input string tag);
        int n = 0;
        while ((exp_q.size() != 0 || rq_pending() != 0) && n < 2000) begin
            @(negedge clk); #1; n++;
        end
        check_eq({tag, "_drain"}, exp_q.size(), 0);
        n = 0;
        while (busy && n < 500) begin
            @(negedge clk); #1; n++;
        end
        check_eq({tag, "_back_to_idle"}, int'(busy), 0);
    endtask

    task automatic wait_xfers(input string tag, input int target);
        int n = 0;
        while (xfer_cnt < target && n < 500) begin
            @(negedge clk); #1; n++;
        end
        check_eq({tag, "_xfer_wait"}, xfer_cnt, target);
    endtask

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_errors);
        $fatal(1, "watchdog");
    end

    initial begin : main
        int c0;
        repeat (3) @(negedge clk);
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_grant_id", int'(grant_id), 0);
        check_eq("rst_tx_valid", int'(bus.tx_data_valid), 0);
        check_eq("rst_tx_data", int'(bus.tx_data), 0);
        check_eq("rst_req_ready", int'(bus.req_ready), 0);
        check_eq("rst_pkt_trunc", int'(pkt_trunc), 0);
        @(posedge clk); #2;
        n_reset = 1'b1;
        repeat (2) @(negedge clk);

        // All four requesters hold 1-byte packets: grants 0,1,2,3,0
        pkt(0, 8'h10, 1, -1);
        pkt(1, 8'h11, 1, NEXT_GAP);
        pkt(2, 8'h12, 1, NEXT_GAP);
        pkt(3, 8'h13, 1, NEXT_GAP);
        push_req(0, 8'h14, 1'b1);
        push_exp(0, 8'h14, 1'b1, 1'b0, NEXT_GAP);
        wait_drain("rr_order");

        // Three-byte packet from requester 0
        pkt(0, 8'h41, 3, -1);
        wait_drain("pkt3");

        // Simultaneous requests after grant 0: rr_ptr=1 favours requester 1
        push_req(0, 8'h50, 1'b1);
        push_req(1, 8'h51, 1'b1);
        push_exp(1, 8'h51, 1'b1, 1'b0, -1);
        push_exp(0, 8'h50, 1'b1, 1'b0, NEXT_GAP);
        wait_drain("rr_ptr_after_pkt");

        // 20-byte stream from requester 2: cut at 16, tail on the next grant
        for (int k = 0; k < 20; k++) begin
            push_req(2, 8'h60 + k, k == 19);
            push_exp(2, 8'h60 + k, (k == 15) || (k == 19), k == 15,
                     (k == 0) ? -1 : ((k == 16) ? NEXT_GAP : -1));
        end
        wait_drain("truncate");

        // Pause mid-packet: packet completes, then no grant until released
        pkt(1, 8'h70, 5, -1);
        wait_xfers("pause_start", xfer_cnt + 1);
        pause = 1'b1;
        pkt(3, 8'h80, 1, -1);
        pkt(0, 8'h90, 1, NEXT_GAP);
        c0 = 0;
        while (exp_q.size() > 2 && c0 < 200) begin
            @(negedge clk); #1; c0++;
        end
        check_eq("pause_pkt_completes", exp_q.size(), 2);
        c0 = 0;
        while (busy && c0 < 200) begin
            @(negedge clk); #1; c0++;
        end
        c0 = xfer_cnt;
        repeat (GAP + 20) @(negedge clk);
        check_eq("pause_no_grant", xfer_cnt - c0, 0);
        check_eq("pause_idle", int'(busy), 0);
        pause = 1'b0;
        wait_drain("pause_resume");

        // Transmitter ready only one cycle in four
        ready_mode = 1'b1;
        c0 = xfer_cnt;
        pkt(3, 8'hA0, 5, -1);
        wait_drain("ready_throttle");
        check_eq("ready_throttle_count", xfer_cnt - c0, 5);
        ready_mode = 1'b0;

        // Reset mid-packet after two bytes; rr_ptr must return to 0
        pkt(2, 8'hB0, 1, -1);
        wait_drain("pre_reset");
        c0 = xfer_cnt;
        pkt(1, 8'hC0, 6, -1);
        wait_xfers("reset_mid", c0 + 2);
        @(posedge clk); #2;
        n_reset = 1'b0;
        #1;
        check_eq("rst_mid_tx_valid", int'(bus.tx_data_valid), 0);
        check_eq("rst_mid_req_ready", int'(bus.req_ready), 0);
        check_eq("rst_mid_busy", int'(busy), 0);
        check_eq("rst_mid_grant_id", int'(grant_id), 0);
        check_eq("rst_mid_tx_data", int'(bus.tx_data), 0);
        check_eq("rst_mid_xfers", xfer_cnt - c0, 2);
        for (int i = 0; i < int'(NR); i++) rq[i].delete();
        exp_q.delete();
        repeat (3) @(posedge clk);
        #2;
        n_reset = 1'b1;
        push_req(3, 8'hD3, 1'b1);
        push_req(0, 8'hD0, 1'b1);
        push_exp(0, 8'hD0, 1'b1, 1'b0, -1);
        push_exp(3, 8'hD3, 1'b1, 1'b0, NEXT_GAP);
        wait_drain("post_reset_rr");

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
